uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
- Sequences program load for the CPU core.
- Consumes the byte stream from the UART receiver and assembles little-endian 32-bit words into instruction memory.
- Holds the core in reset until a framed image passes its checksum, then releases the core and returns ACK/NAK through the UART transmitter.
- Sits in the top level between uart_rx/uart_tx, the instruction memory write port and the core reset.

Parameters:
- ADDR_W, 12, instruction memory word-address width; maximum image is 2**ADDR_W words.
- TIMEOUT_CYCLES, 868000, idle cycles between received bytes before a load aborts (about 1000 bit times at CLOCK_FREQ_OVER_BAUD_RATE=868).

Ports:
- clk  in  1  system clock
- reset_pin  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe from uart_rx: rx_data valid
- rx_data  in  8  received byte
- tx_valid  out  1  response byte valid to uart_tx
- tx_ready  in  1  uart_tx accepts the byte when tx_valid && tx_ready
- tx_data  out  8  response byte
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  word data
- cpu_reset_n  out  1  core reset, active low
- loading  out  1  high from accepted sync byte until RESP handshake completes

Behaviour:
- Reset (reset_pin low, async): state IDLE; outputs tx_valid=0, tx_data=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset_n=0, loading=0. Internal word count, byte index, checksum and timer are all cleared.
- Frame format: 0xA5 sync, LEN_LO, LEN_HI (word count, 16-bit LE), LEN*4 payload bytes (each word LE), CHK.
  - CHK = XOR of all payload bytes only.
- States:
  - IDLE: rx 0xA5 -> LEN_LO and set loading=1; any other byte is ignored.
  - LEN_LO: rx byte -> latch low length byte -> LEN_HI.
  - LEN_HI: latch high byte. If LEN==0 or LEN>2**ADDR_W -> RESP with NAK; else -> DATA, with mem_addr base 0 and checksum cleared.
  - DATA: each rx byte shifts into word buffer at position [8*idx+:8] and XORs into checksum.
    - On the 4th byte, mem_we pulses for exactly one cycle, starting the cycle after that rx_valid, with mem_addr = word index and mem_wdata = assembled word.
    - After the write, the address increments. After LEN words -> CHECK.
  - CHECK: rx byte compared against checksum: equal -> RESP/ACK (0x06), else -> RESP/NAK (0x15).
  - RESP: tx_valid=1 and tx_data held stable until tx_ready. On handshake, tx_valid drops the next cycle and loading=0. ACK -> RUN; NAK -> IDLE. rx bytes are ignored in RESP.
  - RUN: cpu_reset_n=1, asserted the cycle after the ACK handshake. Rx 0xA5 -> cpu_reset_n=0 the next cycle, then -> LEN_LO (reload). Other bytes are ignored.
- Timeout:
  - Active in LEN_LO, LEN_HI, DATA and CHECK.
  - Counter clears on every rx_valid and on state entry, and increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 -> RESP/NAK. Any partial word is discarded and not written.
- Memory written before a NAK is not rolled back; the core stays in reset.
- rx_valid and tx_ready in the same cycle while in RESP: the handshake completes and the byte is dropped.
- Only one byte is processed per cycle. Back-to-back rx_valid on consecutive cycles must be accepted in every state.
- Widths: the length compare is done at 17 bits to avoid overflow; the word counter is ADDR_W+1 bits.

Decomposition:
- Package loader_pkg holds:
  - state enum (IDLE, LEN_LO, LEN_HI, DATA, CHECK, RESP, RUN);
  - constants SYNC_BYTE=8'hA5, ACK_BYTE=8'h06, NAK_BYTE=8'h15.
- Sub-module loader_timer: a clearable saturating counter with a terminal-count flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Good load: A5 02 00 13 05 50 00 73 00 00 00 35 -> mem writes addr0=0x00500513, addr1=0x00000073; tx 0x06; cpu_reset_n rises the cycle after the tx handshake.
- Bad checksum: same frame with CHK=0x34 -> both words written, tx 0x15, cpu_reset_n stays 0, state returns to IDLE; a subsequent good frame loads successfully.
- Length boundaries:
  - LEN=0 (A5 00 00) -> immediate NAK.
  - With ADDR_W=2, LEN=5 -> NAK.
  - With ADDR_W=2, LEN=4 -> four writes at addr 0..3, then ACK.
- Timeout: A5 01 00 13 05, then silence for TIMEOUT_CYCLES -> NAK and no mem_we; a following byte 0x42 is ignored in IDLE.
- Reload and backpressure: in RUN send A5 -> cpu_reset_n=0 the next cycle. Hold tx_ready=0 for 50 cycles during the response -> tx_valid and tx_data stay stable and the state does not change until tx_ready.
- Reset mid-load: assert reset_pin low during the DATA phase -> all outputs return to reset values immediately (async), with no further mem_we after release.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared state encoding and protocol byte values for the UART boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        RESP,
        RUN
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/loader_timer.sv
// Inter-byte idle timer: clearable saturating counter that flags when it
// has sat at TIMEOUT_CYCLES-1 without being cleared.
module loader_timer #(
    parameter int TIMEOUT_CYCLES = 868000
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_done
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count idle cycles, holding at the terminal value until cleared.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != TERM) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = (r_cnt == TERM);

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses a framed image from the UART byte stream, writes
// little-endian words into instruction memory, answers ACK/NAK and releases
// the core reset only after a frame whose checksum matches.
module uart_boot_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 868000
) (
    input  logic              clk,
    input  logic              reset_pin,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset_n,
    output logic              loading
);

    // Largest legal image length, held at 17 bits so 2**16 never wraps.
    localparam logic [16:0] MAX_WORDS = 17'(2**ADDR_W);

    state_t              r_state,     w_state_nx;
    logic [7:0]          r_len_lo,    w_len_lo_nx;
    logic [ADDR_W:0]     r_len,       w_len_nx;
    logic [ADDR_W:0]     r_word_cnt,  w_word_cnt_nx;
    logic [1:0]          r_byte_idx,  w_byte_idx_nx;
    logic [31:0]         r_word_buf,  w_word_buf_nx;
    logic [7:0]          r_chk,       w_chk_nx;
    logic                r_tx_valid,  w_tx_valid_nx;
    logic [7:0]          r_tx_data,   w_tx_data_nx;
    logic                r_mem_we,    w_mem_we_nx;
    logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_nx;
    logic [31:0]         r_mem_wdata, w_mem_wdata_nx;
    logic                r_cpu_rst_n, w_cpu_rst_n_nx;
    logic                r_loading,   w_loading_nx;

    logic [16:0]         w_len17;
    logic [ADDR_W:0]     w_cnt_inc;
    logic                w_tmr_active;
    logic                w_tmr_clr;
    logic                w_tmo;

    assign w_len17      = {1'b0, rx_data, r_len_lo};
    assign w_cnt_inc    = r_word_cnt + 1'b1;
    assign w_tmr_active = (r_state inside {LEN_LO, LEN_HI, DATA, CHECK});
    // Parked at zero outside the receive states, so every entry starts fresh.
    assign w_tmr_clr    = rx_valid | ~w_tmr_active;

    loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .i_rst_n(reset_pin),
        .i_clr  (w_tmr_clr),
        .o_done (w_tmo)
    );

    // State register and all datapath/output registers.
    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            r_state     <= IDLE;
            r_len_lo    <= '0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_byte_idx  <= '0;
            r_word_buf  <= '0;
            r_chk       <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rst_n <= 1'b0;
            r_loading   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_len_lo    <= w_len_lo_nx;
            r_len       <= w_len_nx;
            r_word_cnt  <= w_word_cnt_nx;
            r_byte_idx  <= w_byte_idx_nx;
            r_word_buf  <= w_word_buf_nx;
            r_chk       <= w_chk_nx;
            r_tx_valid  <= w_tx_valid_nx;
            r_tx_data   <= w_tx_data_nx;
            r_mem_we    <= w_mem_we_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_wdata <= w_mem_wdata_nx;
            r_cpu_rst_n <= w_cpu_rst_n_nx;
            r_loading   <= w_loading_nx;
        end
    end

    // Frame parser: next state and next register values; an rx byte takes
    // priority over a timeout landing in the same cycle.
    always_comb begin
        w_state_nx     = r_state;
        w_len_lo_nx    = r_len_lo;
        w_len_nx       = r_len;
        w_word_cnt_nx  = r_word_cnt;
        w_byte_idx_nx  = r_byte_idx;
        w_word_buf_nx  = r_word_buf;
        w_chk_nx       = r_chk;
        w_tx_valid_nx  = r_tx_valid;
        w_tx_data_nx   = r_tx_data;
        w_mem_we_nx    = 1'b0;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        w_cpu_rst_n_nx = r_cpu_rst_n;
        w_loading_nx   = r_loading;

        case (r_state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    w_state_nx   = LEN_LO;
                    w_loading_nx = 1'b1;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    w_len_lo_nx = rx_data;
                    w_state_nx  = LEN_HI;
                end else if (w_tmo) begin
                    w_state_nx    = RESP;
                    w_tx_valid_nx = 1'b1;
                    w_tx_data_nx  = NAK_BYTE;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    if (w_len17 == 17'd0 || w_len17 > MAX_WORDS) begin
                        w_state_nx    = RESP;
                        w_tx_valid_nx = 1'b1;
                        w_tx_data_nx  = NAK_BYTE;
                    end else begin
                        w_state_nx    = DATA;
                        w_len_nx      = w_len17[ADDR_W:0];
                        w_word_cnt_nx = '0;
                        w_byte_idx_nx = '0;
                        w_chk_nx      = '0;
                        w_mem_addr_nx = '0;
                    end
                end else if (w_tmo) begin
                    w_state_nx    = RESP;
                    w_tx_valid_nx = 1'b1;
                    w_tx_data_nx  = NAK_BYTE;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    w_word_buf_nx[8*r_byte_idx +: 8] = rx_data;
                    w_chk_nx      = r_chk ^ rx_data;
                    w_byte_idx_nx = r_byte_idx + 1'b1;
                    if (r_byte_idx == 2'd3) begin
                        w_mem_we_nx    = 1'b1;
                        w_mem_addr_nx  = r_word_cnt[ADDR_W-1:0];
                        w_mem_wdata_nx = w_word_buf_nx;
                        w_word_cnt_nx  = w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            w_state_nx = CHECK;
                        end
                    end
                end else if (w_tmo) begin
                    w_state_nx    = RESP;
                    w_tx_valid_nx = 1'b1;
                    w_tx_data_nx  = NAK_BYTE;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    w_state_nx    = RESP;
                    w_tx_valid_nx = 1'b1;
                    w_tx_data_nx  = (rx_data == r_chk) ? ACK_BYTE : NAK_BYTE;
                end else if (w_tmo) begin
                    w_state_nx    = RESP;
                    w_tx_valid_nx = 1'b1;
                    w_tx_data_nx  = NAK_BYTE;
                end
            end
            RESP: begin
                if (r_tx_valid && tx_ready) begin
                    w_tx_valid_nx = 1'b0;
                    w_loading_nx  = 1'b0;
                    if (r_tx_data == ACK_BYTE) begin
                        w_state_nx     = RUN;
                        w_cpu_rst_n_nx = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            RUN: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    w_state_nx     = LEN_LO;
                    w_cpu_rst_n_nx = 1'b0;
                    w_loading_nx   = 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign cpu_reset_n = r_cpu_rst_n;
    assign loading     = r_loading;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed frames from the test
// plan plus randomized frames, checked against a frame-level reference model.
module tb_uart_boot_loader;

    localparam int ADDR_W = 2;
    localparam int TC     = 64;
    localparam int MAXW   = 1 << ADDR_W;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              reset_pin;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset_n;
    logic              loading;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [31:0]       exp_words[$];
    logic [7:0]        exp_resp;
    bq_t               f;
    int                cyc;

    uart_boot_loader #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk        (clk),
        .reset_pin  (reset_pin),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset_n(cpu_reset_n),
        .loading    (loading)
    );

    always #5 clk = ~clk;

    // Record every memory write strobe seen (one entry per high cycle).
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: what a whole frame should produce (writes and response).
    task automatic model(input bq_t fr);
        int         len;
        logic [7:0] x;
        exp_words.delete();
        x   = 8'h00;
        len = int'({fr[2], fr[1]});
        if (len == 0 || len > MAXW) begin
            exp_resp = NAK;
            return;
        end
        for (int w = 0; w < len; w++) begin
            exp_words.push_back({fr[6+4*w], fr[5+4*w], fr[4+4*w], fr[3+4*w]});
            for (int b = 0; b < 4; b++) x ^= fr[3+4*w+b];
        end
        exp_resp = (fr[3+4*len] == x) ? ACK : NAK;
    endtask

    task automatic make_frame(input int len, input bit good, output bq_t fr);
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] l16;
        x   = 8'h00;
        l16 = 16'(len);
        fr  = {};
        fr.push_back(SYNC);
        fr.push_back(l16[7:0]);
        fr.push_back(l16[15:8]);
        if (len == 0 || len > MAXW) return;
        for (int i = 0; i < 4*len; i++) begin
            b = 8'($urandom);
            fr.push_back(b);
            x ^= b;
        end
        fr.push_back(good ? x : (x ^ 8'h5A));
    endtask

    task automatic send(input bq_t fr, input int gap_max);
        int g;
        for (int i = 0; i < fr.size(); i++) begin
            @(negedge clk);
            if (i == 1 && fr[0] == SYNC) begin
                chk("sync_loading", loading, 1);
                chk("sync_cpu_rst", cpu_reset_n, 0);
            end
            rx_valid = 1'b1;
            rx_data  = fr[i];
            if (gap_max > 0) begin
                g = $urandom_range(0, gap_max);
                repeat (g) begin
                    @(negedge clk);
                    rx_valid = 1'b0;
                    rx_data  = 8'($urandom);
                end
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic finish_resp(input int hold, input bit collide);
        int         n;
        bit         ok;
        logic [7:0] d0;
        n = 0;
        while (tx_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tx_valid_seen", tx_valid, 1);
        if (tx_valid !== 1'b1) return;
        chk("tx_data", tx_data, exp_resp);
        chk("loading_resp", loading, 1);
        chk("cpu_rst_resp", cpu_reset_n, 0);
        chk("wr_count", wr_addr_q.size(), exp_words.size());
        for (int i = 0; i < wr_addr_q.size() && i < exp_words.size(); i++) begin
            chk("wr_addr", wr_addr_q[i], 64'(i));
            chk("wr_data", wr_data_q[i], exp_words[i]);
        end
        d0 = tx_data;
        ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_data === d0 && loading === 1'b1 && cpu_reset_n === 1'b0))
                ok = 1'b0;
        end
        if (hold > 0) chk("tx_hold_stable", ok, 1);
        tx_ready = 1'b1;
        if (collide) begin
            rx_valid = 1'b1;
            rx_data  = SYNC;
        end
        @(negedge clk);
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        chk("tx_drop", tx_valid, 0);
        chk("loading_done", loading, 0);
        chk("cpu_rst_after", cpu_reset_n, (exp_resp == ACK) ? 1 : 0);
    endtask

    task automatic clear_q();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_pin = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {tx_valid, tx_data, mem_we, mem_addr, mem_wdata, cpu_reset_n, loading}, 0);
        reset_pin = 1'b1;

        // Directed good load.
        f = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00, 8'h35};
        clear_q();
        model(f);
        send(f, 0);
        if (wr_data_q.size() == 2) begin
            chk("good_w0", wr_data_q[0], 32'h00500513);
            chk("good_w1", wr_data_q[1], 32'h00000073);
        end
        finish_resp(0, 0);
        chk("good_ack", exp_resp, ACK);

        // Bad checksum, then a good frame with backpressure.
        f[11] = 8'h34;
        clear_q();
        model(f);
        send(f, 0);
        finish_resp(0, 0);
        f[11] = 8'h35;
        clear_q();
        model(f);
        send(f, 2);
        finish_resp(50, 0);

        // Reload from RUN with a full-size image.
        make_frame(4, 1'b1, f);
        clear_q();
        model(f);
        send(f, 0);
        finish_resp(3, 1);

        // Length boundaries.
        f = {8'hA5, 8'h00, 8'h00};
        clear_q();
        model(f);
        send(f, 0);
        finish_resp(0, 0);
        f = {8'hA5, 8'h05, 8'h00};
        clear_q();
        model(f);
        send(f, 0);
        finish_resp(0, 0);

        // Timeout with a partial word.
        f = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h05};
        clear_q();
        send(f, 0);
        cyc = 0;
        while (tx_valid !== 1'b1 && cyc < TC + 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_latency_window", (cyc >= TC - 1 && cyc <= TC + 1) ? 1 : 0, 1);
        exp_words.delete();
        exp_resp = NAK;
        finish_resp(0, 0);
        f = {8'h42};
        send(f, 0);
        repeat (5) @(negedge clk);
        chk("idle_ignore_loading", loading, 0);
        chk("idle_ignore_tx", tx_valid, 0);

        // Randomized frames.
        for (int k = 0; k < 10; k++) begin
            make_frame($urandom_range(0, 6), ($urandom_range(0, 3) != 0), f);
            clear_q();
            model(f);
            send(f, $urandom_range(0, 3));
            finish_resp($urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of DATA.
        f = {8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send(f, 0);
        clear_q();
        #1 reset_pin = 1'b0;
        #1;
        chk("rst_async_outputs", {tx_valid, tx_data, mem_we, mem_addr, mem_wdata, cpu_reset_n, loading}, 0);
        @(negedge clk);
        reset_pin = 1'b1;
        f = {8'h88, 8'h99};
        send(f, 0);
        repeat (10) @(negedge clk);
        chk("no_we_after_rst", wr_addr_q.size(), 0);
        chk("rst_idle_loading", loading, 0);

        // Recovery load after reset.
        make_frame(3, 1'b1, f);
        clear_q();
        model(f);
        send(f, 1);
        finish_resp(2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
